// File: rtl/apb_quad_slave_bridge_if.sv
`default_nettype none
// ============================================================================
// apb_quad_slave_bridge_if : APB bus bundle between master and quad-bank bridge
// Rev 1.0
// ============================================================================
interface apb_quad_slave_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic              enable;
    logic              sel1;
    logic              sel2;
    logic              sel3;
    logic              sel4;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output data, addr, write, enable, sel1, sel2, sel3, sel4,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  data, addr, write, enable, sel1, sel2, sel3, sel4,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_quad_slave_bridge.sv
`default_nettype none
// ============================================================================
// apb_quad_slave_bridge : APB slave with one wait state fronting four banks
// Rev 1.0
// ============================================================================
module apb_quad_slave_bridge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  wire logic              PCLK,
    input  wire logic              PRESETn,
    apb_quad_slave_bridge_if.slave apb
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              write_q;
    logic [3:0]        sel_q;
    logic [DATA_W-1:0] prdata_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] mem_q [4][DEPTH];

    logic [3:0]        w_sel;
    logic              w_anysel;
    logic [1:0]        w_bank;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;

    assign w_sel    = {apb.sel4, apb.sel3, apb.sel2, apb.sel1};
    assign w_anysel = |w_sel;
    assign w_idx    = addr_q[IDX_W-1:0];

    // Multi-select or out-of-range word index completes with an error and no access.
    assign w_err = ($countones(sel_q) > 1) || (addr_q >= ADDR_W'(DEPTH));

    always_comb begin
        w_bank = 2'd0;
        case (sel_q)
            4'b0010: w_bank = 2'd1;
            4'b0100: w_bank = 2'd2;
            4'b1000: w_bank = 2'd3;
            default: w_bank = 2'd0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            sel_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (w_anysel && !apb.enable) begin
                        addr_q  <= apb.addr;
                        data_q  <= apb.data;
                        write_q <= apb.write;
                        sel_q   <= w_sel;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!w_anysel) begin
                        state_q <= ST_IDLE;
                    end else if (apb.enable) begin
                        pready_q <= 1'b1;
                        state_q  <= ST_ACCESS;
                        if (w_err) begin
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                        end else if (write_q) begin
                            mem_q[w_bank][w_idx] <= data_q;
                            prdata_q  <= '0;
                            pslverr_q <= 1'b0;
                        end else begin
                            prdata_q  <= mem_q[w_bank][w_idx];
                            pslverr_q <= 1'b0;
                        end
                    end else begin
                        addr_q  <= apb.addr;
                        data_q  <= apb.data;
                        write_q <= apb.write;
                        sel_q   <= w_sel;
                    end
                end
                ST_ACCESS: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (w_anysel && !apb.enable) begin
                        addr_q  <= apb.addr;
                        data_q  <= apb.data;
                        write_q <= apb.write;
                        sel_q   <= w_sel;
                        state_q <= ST_SETUP;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
            endcase
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_quad_slave_bridge.sv
`default_nettype none
// ============================================================================
// tb_apb_quad_slave_bridge : directed self-checking bench for the quad bridge
// Rev 1.0
// ============================================================================
module tb_apb_quad_slave_bridge;
    logic PCLK;
    logic PRESETn;
    int   total;
    int   bad;

    apb_quad_slave_bridge_if #(.DATA_W(32), .ADDR_W(8)) apb ();

    apb_quad_slave_bridge #(.DATA_W(32), .ADDR_W(8), .DEPTH(16)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (apb)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] s, input logic [7:0] a, input logic w,
                         input logic [31:0] d, input logic en);
        apb.sel1   = s[0];
        apb.sel2   = s[1];
        apb.sel3   = s[2];
        apb.sel4   = s[3];
        apb.addr   = a;
        apb.write  = w;
        apb.data   = d;
        apb.enable = en;
    endtask

    // One full transfer: setup, enable, then sample the completion cycle.
    task automatic xfer(input logic [3:0] s, input logic [7:0] a, input logic w,
                        input logic [31:0] d, output logic rdy_early,
                        output logic rdy, output logic err, output logic [31:0] rd);
        @(negedge PCLK);
        drive(s, a, w, d, 1'b0);
        @(negedge PCLK);
        rdy_early  = apb.PREADY;
        apb.enable = 1'b1;
        @(negedge PCLK);
        rdy = apb.PREADY;
        err = apb.PSLVERR;
        rd  = apb.PRDATA;
        drive(4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        logic e, r, er;
        logic [31:0] rd;
        PRESETn = 1'b0;
        drive(4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge PCLK);
        total++;
        if (apb.PREADY !== 1'b0 || apb.PSLVERR !== 1'b0 || apb.PRDATA !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h want 0/0/0",
                     apb.PREADY, apb.PSLVERR, apb.PRDATA);
        end
        PRESETn = 1'b1;
        @(negedge PCLK);
        total++;
        if (apb.PREADY !== 1'b0 || apb.PSLVERR !== 1'b0 || apb.PRDATA !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_outputs: got rdy=%b err=%b rd=%h want 0/0/0",
                     apb.PREADY, apb.PSLVERR, apb.PRDATA);
        end
        xfer(4'b0010, 8'd5, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (r !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL reset_read_b2a5: got rdy=%b err=%b rd=%h want 1/0/0", r, er, rd);
        end
    endtask

    task automatic test_write_read();
        logic e, r, er;
        logic [31:0] rd;
        xfer(4'b0001, 8'd3, 1'b1, 32'hDEADBEEF, e, r, er, rd);
        total++;
        if (e !== 1'b0 || r !== 1'b1 || er !== 1'b0) begin
            bad++;
            $display("FAIL write_latency: got early=%b rdy=%b err=%b want 0/1/0", e, r, er);
        end
        @(negedge PCLK);
        total++;
        if (apb.PREADY !== 1'b0) begin
            bad++;
            $display("FAIL pready_one_cycle: got %b want 0", apb.PREADY);
        end
        xfer(4'b0001, 8'd3, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (r !== 1'b1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_b1a3: got rdy=%b err=%b rd=%h want 1/0/deadbeef", r, er, rd);
        end
        @(negedge PCLK);
        total++;
        if (apb.PRDATA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL prdata_hold: got %h want deadbeef", apb.PRDATA);
        end
        xfer(4'b1000, 8'd15, 1'b1, 32'hCAFE0015, e, r, er, rd);
        xfer(4'b1000, 8'd15, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (er !== 1'b0 || rd !== 32'hCAFE0015) begin
            bad++;
            $display("FAIL last_word_b4a15: got err=%b rd=%h want 0/cafe0015", er, rd);
        end
    endtask

    task automatic test_bank_isolation();
        logic e, r, er;
        logic [31:0] rd;
        xfer(4'b0010, 8'd7, 1'b1, 32'h1234, e, r, er, rd);
        xfer(4'b0100, 8'd7, 1'b1, 32'h5678, e, r, er, rd);
        xfer(4'b0010, 8'd7, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (rd !== 32'h1234) begin
            bad++;
            $display("FAIL iso_b2a7: got %h want 00001234", rd);
        end
        xfer(4'b0100, 8'd7, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (rd !== 32'h5678) begin
            bad++;
            $display("FAIL iso_b3a7: got %h want 00005678", rd);
        end
        xfer(4'b1000, 8'd7, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL iso_b4a7: got %h want 00000000", rd);
        end
    endtask

    task automatic test_errors();
        logic e, r, er;
        logic [31:0] rd;
        xfer(4'b0011, 8'd0, 1'b1, 32'hFFFF, e, r, er, rd);
        total++;
        if (r !== 1'b1 || er !== 1'b1) begin
            bad++;
            $display("FAIL multisel_err: got rdy=%b err=%b want 1/1", r, er);
        end
        @(negedge PCLK);
        total++;
        if (apb.PSLVERR !== 1'b0 || apb.PREADY !== 1'b0) begin
            bad++;
            $display("FAIL err_clears: got rdy=%b err=%b want 0/0", apb.PREADY, apb.PSLVERR);
        end
        xfer(4'b0001, 8'd0, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL multisel_b1_untouched: got err=%b rd=%h want 0/0", er, rd);
        end
        xfer(4'b0010, 8'd0, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL multisel_b2_untouched: got err=%b rd=%h want 0/0", er, rd);
        end
        // Prime PRDATA non-zero so the error path's clear is observable.
        xfer(4'b0001, 8'd3, 1'b0, 32'h0, e, r, er, rd);
        xfer(4'b1000, 8'd20, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (r !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL range_err_b4a20: got rdy=%b err=%b rd=%h want 1/1/0", r, er, rd);
        end
        xfer(4'b1000, 8'd16, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL range_err_a16: got err=%b want 1", er);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge PCLK);
        drive(4'b0001, 8'd1, 1'b1, 32'hA5, 1'b0);
        @(negedge PCLK);
        apb.enable = 1'b1;
        @(negedge PCLK);
        total++;
        if (apb.PREADY !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_ready: got %b want 1", apb.PREADY);
        end
        drive(4'b0001, 8'd1, 1'b0, 32'h0, 1'b0);
        @(negedge PCLK);
        total++;
        if (apb.PREADY !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: got %b want 0", apb.PREADY);
        end
        apb.enable = 1'b1;
        @(negedge PCLK);
        total++;
        if (apb.PREADY !== 1'b1 || apb.PSLVERR !== 1'b0 || apb.PRDATA !== 32'hA5) begin
            bad++;
            $display("FAIL b2b_read: got rdy=%b err=%b rd=%h want 1/0/000000a5",
                     apb.PREADY, apb.PSLVERR, apb.PRDATA);
        end
        drive(4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_abort_and_reset();
        logic e, r, er;
        logic [31:0] rd;
        logic seen;
        @(negedge PCLK);
        drive(4'b0001, 8'd2, 1'b0, 32'h0, 1'b1);
        seen = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            if (apb.PREADY !== 1'b0) seen = 1'b1;
        end
        drive(4'b0100, 8'd9, 1'b1, 32'h77, 1'b0);
        @(negedge PCLK);
        drive(4'b0000, 8'd9, 1'b1, 32'h77, 1'b0);
        repeat (3) begin
            @(negedge PCLK);
            if (apb.PREADY !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL idle_enable_and_abort_no_ready: got ready seen=%b want 0", seen);
        end
        xfer(4'b0100, 8'd9, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL abort_mem_unchanged: got %h want 0", rd);
        end
        @(negedge PCLK);
        drive(4'b0001, 8'd10, 1'b1, 32'h99, 1'b0);
        @(negedge PCLK);
        apb.enable = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        total++;
        if (apb.PREADY !== 1'b0 || apb.PSLVERR !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ready: got rdy=%b err=%b want 0/0", apb.PREADY, apb.PSLVERR);
        end
        drive(4'b0000, 8'h00, 1'b0, 32'h0, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(4'b0001, 8'd10, 1'b0, 32'h0, e, r, er, rd);
        total++;
        if (r !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL midreset_cleared: got rdy=%b rd=%h want 1/0", r, rd);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_bank_isolation();
        test_errors();
        test_back_to_back();
        test_abort_and_reset();
        repeat (2) @(negedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
